alu_datapath: RTL and testbench

//  Register/arithmetic datapath driven by the 18-bit control word c[17:0] from Control_Unit.

---
 rtl/alu_datapath.sv | 213 +++++++++++++++++++++
 tb/tb_alu_datapath.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_datapath.sv
// Booth/restoring-divide datapath steered by an 18-bit control word from the control unit.
// Optional Z/N/V result flags are compiled in when ALU_FLAGS_EN is defined.
module alu_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [17:0]      c,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             out_vld,
    output logic             Q1,
    output logic             Q0,
    output logic             R,
    output logic             A7,
    output logic             count7
`ifdef ALU_FLAGS_EN
    ,
    output logic             Z,
    output logic             N,
    output logic             V
`endif
);

    localparam int AW = WIDTH + 2;

    logic [AW-1:0]    a_r;
    logic [WIDTH-1:0] q_r;
    logic             qm1_r;
    logic [WIDTH-1:0] m_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] outbus_r;
    logic             out_vld_r;

    logic [AW-1:0]    sx_m_s;
    logic [AW-1:0]    sx_2m_s;
    logic [AW-1:0]    sum_s;
    logic [AW-1:0]    a_sh_s;
    logic [WIDTH-1:0] q_sh_s;
    logic             qm1_sh_s;
    logic [WIDTH-1:0] q_lg_s;
    logic [WIDTH-1:0] q_set_s;
    logic [AW-1:0]    a_nxt_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic             qm1_nxt_s;
    logic [WIDTH-1:0] m_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] out_nxt_s;
    logic             vld_nxt_s;
    logic             unused_rsv_s;

    assign unused_rsv_s = ^c[17:16];

    assign sx_m_s  = {{2{m_r[WIDTH-1]}}, m_r};
    assign sx_2m_s = {m_r[WIDTH-1], m_r, 1'b0};

    // Add group: the lowest set bit of c[5:2] selects the operation.
    always_comb begin
        sum_s = a_r;
        if (c[2]) begin
            sum_s = a_r + sx_m_s;
        end else if (c[3]) begin
            sum_s = a_r - sx_m_s;
        end else if (c[4]) begin
            sum_s = a_r + sx_2m_s;
        end else if (c[5]) begin
            sum_s = a_r - sx_2m_s;
        end else begin
            sum_s = a_r;
        end
    end

    // Shift stage acts on the freshly formed sum so one word can be a full Booth step.
    always_comb begin
        a_sh_s   = sum_s;
        q_sh_s   = q_r;
        qm1_sh_s = qm1_r;
        if (c[6]) begin
            a_sh_s   = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
            q_sh_s   = {sum_s[1:0], q_r[WIDTH-1:2]};
            qm1_sh_s = q_r[1];
        end else if (c[7]) begin
            a_sh_s   = {sum_s[AW-2:0], q_r[WIDTH-1]};
            q_sh_s   = {q_r[WIDTH-2:0], 1'b0};
            qm1_sh_s = qm1_r;
        end else begin
            a_sh_s   = sum_s;
            q_sh_s   = q_r;
            qm1_sh_s = qm1_r;
        end
    end

    // Logic group on Q (lowest bit wins), then the quotient-bit set.
    always_comb begin
        q_lg_s = q_sh_s;
        if (c[10]) begin
            q_lg_s = q_sh_s & m_r;
        end else if (c[11]) begin
            q_lg_s = q_sh_s | m_r;
        end else if (c[12]) begin
            q_lg_s = q_sh_s ^ m_r;
        end else begin
            q_lg_s = q_sh_s;
        end
        q_set_s = q_lg_s;
        if (c[8]) begin
            q_set_s[0] = 1'b1;
        end else begin
            q_set_s[0] = q_lg_s[0];
        end
    end

    // Final next-state selection: LOAD_Q overrides every A/Q write.
    always_comb begin
        a_nxt_s   = a_sh_s;
        q_nxt_s   = q_set_s;
        qm1_nxt_s = qm1_sh_s;
        if (c[0]) begin
            a_nxt_s   = {AW{1'b0}};
            q_nxt_s   = inbus;
            qm1_nxt_s = 1'b0;
        end else begin
            a_nxt_s   = a_sh_s;
            q_nxt_s   = q_set_s;
            qm1_nxt_s = qm1_sh_s;
        end

        if (c[1]) begin
            m_nxt_s = inbus;
        end else begin
            m_nxt_s = m_r;
        end

        if (c[15]) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (c[9]) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if (c[13]) begin
            out_nxt_s = a_r[WIDTH-1:0];
        end else if (c[14]) begin
            out_nxt_s = q_r;
        end else begin
            out_nxt_s = outbus_r;
        end
        vld_nxt_s = c[13] | c[14];
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r       <= {AW{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            qm1_r     <= 1'b0;
            m_r       <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            outbus_r  <= {WIDTH{1'b0}};
            out_vld_r <= 1'b0;
        end else begin
            a_r       <= a_nxt_s;
            q_r       <= q_nxt_s;
            qm1_r     <= qm1_nxt_s;
            m_r       <= m_nxt_s;
            cnt_r     <= cnt_nxt_s;
            outbus_r  <= out_nxt_s;
            out_vld_r <= vld_nxt_s;
        end
    end

    assign outbus  = outbus_r;
    assign out_vld = out_vld_r;
    assign Q1      = q_r[1];
    assign Q0      = q_r[0];
    assign R       = qm1_r;
    assign A7      = a_r[AW-1];
    assign count7  = &cnt_r;

`ifdef ALU_FLAGS_EN
    logic z_r;
    logic n_r;
    logic v_r;
    logic v_s;

    // Overflow: A's guard bits disagree with the sign of the visible result.
    assign v_s = ~((&a_r[WIDTH+1:WIDTH-1]) | (~|a_r[WIDTH+1:WIDTH-1]));

    // Flags are captured together with the result bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_r <= 1'b0;
            n_r <= 1'b0;
            v_r <= 1'b0;
        end else if (vld_nxt_s) begin
            z_r <= (out_nxt_s == {WIDTH{1'b0}});
            n_r <= out_nxt_s[WIDTH-1];
            v_r <= v_s;
        end else begin
            z_r <= z_r;
            n_r <= n_r;
            v_r <= v_r;
        end
    end

    assign Z = z_r;
    assign N = n_r;
    assign V = v_r;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: acts as the control unit and scoreboards outbus.
module tb_alu_datapath;

    localparam logic [17:0] LOAD_Q  = 18'h00001;
    localparam logic [17:0] LOAD_M  = 18'h00002;
    localparam logic [17:0] ADD_M   = 18'h00004;
    localparam logic [17:0] SUB_M   = 18'h00008;
    localparam logic [17:0] ADD_2M  = 18'h00010;
    localparam logic [17:0] SUB_2M  = 18'h00020;
    localparam logic [17:0] SHR2    = 18'h00040;
    localparam logic [17:0] SHL1    = 18'h00080;
    localparam logic [17:0] SET_Q0  = 18'h00100;
    localparam logic [17:0] CNT_INC = 18'h00200;
    localparam logic [17:0] Q_AND   = 18'h00400;
    localparam logic [17:0] OUT_A   = 18'h02000;
    localparam logic [17:0] OUT_Q   = 18'h04000;
    localparam logic [17:0] CLR_CNT = 18'h08000;
    localparam logic [17:0] RSV     = 18'h30000;

    logic        clk;
    logic        reset;
    logic [17:0] c;
    logic [7:0]  inbus;
    logic [7:0]  outbus;
    logic        out_vld;
    logic        Q1, Q0, R, A7, count7;
`ifdef ALU_FLAGS_EN
    logic        Z, N, V;
`endif

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    alu_datapath #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .c(c), .inbus(inbus),
        .outbus(outbus), .out_vld(out_vld),
        .Q1(Q1), .Q0(Q0), .R(R), .A7(A7), .count7(count7)
`ifdef ALU_FLAGS_EN
        , .Z(Z), .N(N), .V(V)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every out_vld pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && out_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: outbus=%h with no expected result queued", outbus);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++;
                if (outbus !== e) begin
                    failures++;
                    $display("FAIL outbus: got %h expected %h", outbus, e);
                end
            end
        end
    end

    task automatic step(input logic [17:0] cw, input logic [7:0] din);
        c = cw;
        inbus = din;
        @(posedge clk);
        #1;
        c = 18'd0;
        inbus = 8'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        c = 18'd0;
        inbus = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({outbus, out_vld, Q1, Q0, R, A7, count7} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state: got %h expected 0", {outbus, out_vld, Q1, Q0, R, A7, count7});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_and();
        step(LOAD_Q, 8'hC3);
        step(LOAD_M, 8'h5A);
        step(Q_AND, 8'h00);
        exp_q.push_back(8'h42);
        step(OUT_Q, 8'h00);
        checks++;
        if (out_vld !== 1'b1) begin
            failures++;
            $display("FAIL and_vld_high: got %b expected 1", out_vld);
        end
        step(18'd0, 8'h00);
        checks++;
        if (out_vld !== 1'b0 || outbus !== 8'h42) begin
            failures++;
            $display("FAIL and_vld_pulse: vld=%b outbus=%h expected 0/42", out_vld, outbus);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if ({Z, N} !== 2'b00) begin
            failures++;
            $display("FAIL flags_and: got %b expected 00", {Z, N});
        end
`endif
    endtask

    task automatic test_add();
        step(LOAD_Q, 8'd0);
        step(LOAD_M, 8'd100);
        step(ADD_M, 8'd0);
        step(LOAD_M, 8'd27);
        step(ADD_M, 8'd0);
        exp_q.push_back(8'h7F);
        step(OUT_A, 8'd0);
        // All four add bits set: ADD_M (lowest) applies, 127+27=154.
        step(ADD_M | SUB_M | ADD_2M | SUB_2M, 8'd0);
        exp_q.push_back(8'h9A);
        step(OUT_A | OUT_Q, 8'd0);
        step(SUB_2M, 8'd0);
        exp_q.push_back(8'd100);
        step(OUT_A, 8'd0);
        step(SUB_2M, 8'd0);
        step(SUB_2M, 8'd0);
        checks++;
        if (A7 !== 1'b1) begin
            failures++;
            $display("FAIL add_negative_sign: A7=%b expected 1", A7);
        end
        exp_q.push_back(8'hF8);
        step(OUT_A, 8'd0);
        // LOAD_M together with ADD_M adds the old M (27): -8+27=19.
        step(LOAD_M | ADD_M, 8'd5);
        checks++;
        if (A7 !== 1'b0) begin
            failures++;
            $display("FAIL add_old_m_sign: A7=%b expected 0", A7);
        end
        exp_q.push_back(8'd19);
        step(OUT_A, 8'd0);
    endtask

    task automatic test_priority();
        step(LOAD_M, 8'd9);
        step(LOAD_Q, 8'h81);
        step(SHR2 | SHL1, 8'd0);
        checks++;
        if ({Q1, Q0, R} !== 3'b000) begin
            failures++;
            $display("FAIL shr_wins_status: got %b expected 000", {Q1, Q0, R});
        end
        exp_q.push_back(8'h20);
        step(OUT_Q, 8'd0);
        step(LOAD_Q | ADD_M | SET_Q0, 8'h54);
        exp_q.push_back(8'h00);
        step(OUT_A, 8'd0);
        exp_q.push_back(8'h54);
        step(OUT_Q, 8'd0);
    endtask

    task automatic test_mul(input logic [7:0] qv, input logic [7:0] mv);
        logic [15:0]  prod;
        logic [2:0]   trip;
        logic [17:0]  cw;
        prod = 16'($signed(qv) * $signed(mv));
        step(LOAD_Q, qv);
        step(LOAD_M, mv);
        for (int i = 0; i < 4; i++) begin
            trip = {qv[2*i+1], qv[2*i], (i == 0) ? 1'b0 : qv[2*i-1]};
            checks++;
            if ({Q1, Q0, R} !== trip) begin
                failures++;
                $display("FAIL mul_booth_bits step %0d: got %b expected %b", i, {Q1, Q0, R}, trip);
            end
            case (trip)
                3'b001, 3'b010: cw = ADD_M;
                3'b011:         cw = ADD_2M;
                3'b100:         cw = SUB_2M;
                3'b101, 3'b110: cw = SUB_M;
                default:        cw = 18'd0;
            endcase
            step(cw | SHR2 | CNT_INC, 8'd0);
        end
        exp_q.push_back(prod[15:8]);
        step(OUT_A, 8'd0);
        exp_q.push_back(prod[7:0]);
        step(OUT_Q, 8'd0);
    endtask

    task automatic test_div(input logic [7:0] dvd, input logic [7:0] dvs);
        int         a_m;
        logic [7:0] q_m;
        logic [7:0] quo;
        logic [7:0] rem;
        quo = dvd / dvs;
        rem = dvd % dvs;
        a_m = 0;
        q_m = dvd;
        step(LOAD_Q, dvd);
        step(LOAD_M, dvs);
        for (int i = 0; i < 8; i++) begin
            step(SHL1, 8'd0);
            a_m = a_m * 2 + int'(q_m[7]);
            q_m = {q_m[6:0], 1'b0};
            step(SUB_M, 8'd0);
            a_m = a_m - int'(dvs);
            checks++;
            if (A7 !== (a_m < 0)) begin
                failures++;
                $display("FAIL div_sign iter %0d: A7=%b expected %b", i, A7, (a_m < 0));
            end
            if (a_m < 0) begin
                step(ADD_M, 8'd0);
                a_m = a_m + int'(dvs);
            end else begin
                step(SET_Q0, 8'd0);
                q_m[0] = 1'b1;
            end
        end
        exp_q.push_back(quo);
        step(OUT_Q, 8'd0);
        exp_q.push_back(rem);
        step(OUT_A, 8'd0);
    endtask

    task automatic test_counter();
        step(CLR_CNT, 8'd0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (count7 !== 1'b0) begin
                failures++;
                $display("FAIL cnt_early after %0d incs: count7=%b expected 0", i, count7);
            end
            step(CNT_INC | RSV, 8'd0);
        end
        checks++;
        if (count7 !== 1'b1) begin
            failures++;
            $display("FAIL cnt_seven: count7=%b expected 1", count7);
        end
        step(CNT_INC, 8'd0);
        checks++;
        if (count7 !== 1'b0) begin
            failures++;
            $display("FAIL cnt_wrap: count7=%b expected 0", count7);
        end
        for (int i = 0; i < 6; i++) begin
            step(CNT_INC, 8'd0);
        end
        step(CNT_INC | CLR_CNT, 8'd0);
        checks++;
        if (count7 !== 1'b0) begin
            failures++;
            $display("FAIL cnt_clear_wins: count7=%b expected 0", count7);
        end
    endtask

    task automatic test_reset_mid_mul();
        step(LOAD_Q, 8'hFD);
        step(LOAD_M, 8'd7);
        exp_q.push_back(8'hFD);
        step(OUT_Q | CNT_INC, 8'd0);
        step(ADD_M | SHR2 | CNT_INC, 8'd0);
        c = SUB_M | SHR2 | CNT_INC;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({outbus, out_vld, Q1, Q0, R, A7, count7} !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid_mul: got %h expected 0", {outbus, out_vld, Q1, Q0, R, A7, count7});
        end
        c = 18'd0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(8'h00);
        step(OUT_A, 8'd0);
        exp_q.push_back(8'h00);
        step(OUT_Q, 8'd0);
        step(18'd0, 8'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_and();
        test_add();
        test_priority();
        test_mul(8'hFD, 8'd7);
        test_mul(8'd127, 8'h80);
        test_mul(8'h80, 8'h80);
        test_div(8'd100, 8'd7);
        test_div(8'd200, 8'd13);
        test_counter();
        test_reset_mid_mul();
        step(18'd0, 8'd0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d results never appeared, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
